// File: rtl/adder_pkg.sv
// Shared definitions for the serial adder family: FSM state encoding and
// the slice-counter width helper.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A single-slice configuration still needs a one-bit counter.
    function automatic int cnt_width(input int width, input int slice);
        int n;
        int w;
        n = width / slice;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Start/done handshake, operands and result bus of the serial adder.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output start, sub, a, b, cin,
        input  busy, done, sum, cout, overflow
    );

    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, sum, cout, overflow
    );
endinterface

// File: rtl/slice_adder.sv
// Combinational ripple chain of SLICE full-adder cells; also exposes the
// carry into the top bit so the caller can derive signed overflow.
module slice_adder #(
    parameter int SLICE = 1
) (
    input  logic [SLICE-1:0] x,
    input  logic [SLICE-1:0] y,
    input  logic             ci,
    output logic [SLICE-1:0] s,
    output logic             co,
    output logic             c_msb_in
);
    logic [SLICE:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < SLICE; i++) begin : g_fa
        assign s[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end

    assign co       = c[SLICE];
    assign c_msb_in = c[SLICE-1];
endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: adds SLICE bits per clock, LSB slice first,
// with the inter-slice carry held in a register.
module serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SLICE = 1
) (
    input logic           clk,
    input logic           rst,
    serial_adder_if.slave bus
);
    localparam int N  = WIDTH / SLICE;
    localparam int CW = cnt_width(WIDTH, SLICE);

    if (WIDTH < 2 || (WIDTH % SLICE) != 0) begin : g_param_check
        $fatal(1, "serial_adder: WIDTH must be >= 2 and a multiple of SLICE");
    end

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] sum_r;
    logic             carry;
    logic [CW-1:0]    count;
    logic             busy_r;
    logic             done_r;
    logic             cout_r;
    logic             ovf_r;

    logic [SLICE-1:0] s;
    logic             co;
    logic             c_msb_in;
    logic             accept;
    logic             last_slice;
    logic [WIDTH-1:0] sum_shift;

    slice_adder #(.SLICE(SLICE)) u_slice (
        .x        (op_a[SLICE-1:0]),
        .y        (op_b[SLICE-1:0]),
        .ci       (carry),
        .s        (s),
        .co       (co),
        .c_msb_in (c_msb_in)
    );

    assign accept     = (state == IDLE || state == DONE) && bus.start;
    assign last_slice = (count == CW'(N - 1));
    // New slice enters at the MSB end; after N slices the LSB slice sits at bit 0.
    assign sum_shift  = WIDTH'({s, sum_r} >> SLICE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            op_a   <= '0;
            op_b   <= '0;
            sum_r  <= '0;
            carry  <= 1'b0;
            count  <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        op_a   <= bus.a;
                        op_b   <= bus.sub ? ~bus.b : bus.b;
                        carry  <= bus.sub ? 1'b1 : bus.cin;
                        count  <= '0;
                        sum_r  <= '0;
                        cout_r <= 1'b0;
                        ovf_r  <= 1'b0;
                        busy_r <= 1'b1;
                        state  <= RUN;
                    end else begin
                        busy_r <= 1'b0;
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    sum_r <= sum_shift;
                    op_a  <= op_a >> SLICE;
                    op_b  <= op_b >> SLICE;
                    carry <= co;
                    count <= count + CW'(1);
                    if (last_slice) begin
                        cout_r <= co;
                        ovf_r  <= co ^ c_msb_in;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        state  <= DONE;
                    end
                end
                default: begin
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.sum      = sum_r;
    assign bus.cout     = cout_r;
    assign bus.overflow = ovf_r;
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder across three WIDTH/SLICE configurations
// (8x1, 8x4, 4x2); expectations are queued at start and popped on done.
module tb_serial_adder;

    typedef struct packed {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(8)) if8x1 ();
    serial_adder_if #(.WIDTH(8)) if8x4 ();
    serial_adder_if #(.WIDTH(4)) if4x2 ();

    serial_adder #(.WIDTH(8), .SLICE(1)) u_8x1 (.clk(clk), .rst(rst), .bus(if8x1.slave));
    serial_adder #(.WIDTH(8), .SLICE(4)) u_8x4 (.clk(clk), .rst(rst), .bus(if8x4.slave));
    serial_adder #(.WIDTH(4), .SLICE(2)) u_4x2 (.clk(clk), .rst(rst), .bus(if4x2.slave));

    task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Independent arithmetic reference: integer add, signed overflow from operand/result signs.
    function automatic exp_t model(input int w, input logic [7:0] a, input logic [7:0] b,
                                   input logic cin, input logic sub);
        exp_t e;
        int   mask;
        int   av;
        int   bv;
        int   s;
        int   r;
        mask  = (1 << w) - 1;
        av    = int'(a) & mask;
        bv    = (sub ? ~int'(b) : int'(b)) & mask;
        s     = av + bv + (sub ? 1 : int'(cin));
        r     = s & mask;
        e.sum  = r[7:0];
        e.cout = ((s >> w) & 1) != 0;
        e.ovf  = (av[w-1] == bv[w-1]) && (r[w-1] != av[w-1]);
        return e;
    endfunction

    function automatic exp_t mk(input logic [7:0] sum, input logic cout, input logic ovf);
        exp_t e;
        e.sum  = sum;
        e.cout = cout;
        e.ovf  = ovf;
        return e;
    endfunction

    task automatic set_inputs(input int sel, input logic [7:0] a, input logic [7:0] b,
                              input logic cin, input logic sub, input logic start);
        case (sel)
            0: begin if8x1.a = a; if8x1.b = b; if8x1.cin = cin; if8x1.sub = sub; if8x1.start = start; end
            1: begin if8x4.a = a; if8x4.b = b; if8x4.cin = cin; if8x4.sub = sub; if8x4.start = start; end
            default: begin
                if4x2.a = a[3:0]; if4x2.b = b[3:0]; if4x2.cin = cin; if4x2.sub = sub; if4x2.start = start;
            end
        endcase
    endtask

    function automatic logic get_done(input int sel);
        case (sel)
            0:       return if8x1.done;
            1:       return if8x4.done;
            default: return if4x2.done;
        endcase
    endfunction

    function automatic logic get_busy(input int sel);
        case (sel)
            0:       return if8x1.busy;
            1:       return if8x4.busy;
            default: return if4x2.busy;
        endcase
    endfunction

    // {busy, done, cout, overflow, sum}
    function automatic logic [11:0] get_outs(input int sel);
        case (sel)
            0:       return {if8x1.busy, if8x1.done, if8x1.cout, if8x1.overflow, if8x1.sum};
            1:       return {if8x4.busy, if8x4.done, if8x4.cout, if8x4.overflow, if8x4.sum};
            default: return {if4x2.busy, if4x2.done, if4x2.cout, if4x2.overflow, 4'h0, if4x2.sum};
        endcase
    endfunction

    task automatic push_exp(input int sel, input exp_t e);
        case (sel)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    // Called at a negedge; returns at the negedge where done is observed.
    // poke >= 1 pulses start with junk operands during RUN cycle 'poke'.
    task automatic apply_stimulus(input int sel, input logic [7:0] a, input logic [7:0] b,
                                  input logic cin, input logic sub, input exp_t e,
                                  input int n, input int poke);
        int cycles;
        int busy_cnt;
        set_inputs(sel, a, b, cin, sub, 1'b1);
        push_exp(sel, e);
        @(negedge clk);
        check_output("busy_after_accept", 32'(get_busy(sel)), 32'd1);
        busy_cnt = int'(get_busy(sel));
        set_inputs(sel, ~a, ~b, ~cin, ~sub, 1'b0);
        cycles = 0;
        while (get_done(sel) !== 1'b1 && cycles < 50) begin
            @(negedge clk);
            cycles++;
            busy_cnt += int'(get_busy(sel));
            if (cycles == poke)
                set_inputs(sel, 8'hAA, 8'h55, 1'b1, ~sub, 1'b1);
            if (cycles == poke + 1)
                set_inputs(sel, 8'hAA, 8'h55, 1'b1, ~sub, 1'b0);
        end
        check_output("done_latency", 32'(cycles), 32'(n));
        check_output("busy_cycles", 32'(busy_cnt), 32'(n));
    endtask

    task automatic idle_check(input int sel);
        set_inputs(sel, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_output("done_one_cycle", 32'(get_done(sel)), 32'd0);
        check_output("idle_not_busy", 32'(get_busy(sel)), 32'd0);
    endtask

    always @(negedge clk) begin : mon_8x1
        exp_t e;
        if (if8x1.done === 1'b1) begin
            check_output("sb_pending_8x1", 32'(q0.size() > 0), 32'd1);
            if (q0.size() > 0) begin
                e = q0.pop_front();
                check_output("sum_8x1", 32'(if8x1.sum), 32'(e.sum));
                check_output("cout_8x1", 32'(if8x1.cout), 32'(e.cout));
                check_output("ovf_8x1", 32'(if8x1.overflow), 32'(e.ovf));
            end
        end
    end

    always @(negedge clk) begin : mon_8x4
        exp_t e;
        if (if8x4.done === 1'b1) begin
            check_output("sb_pending_8x4", 32'(q1.size() > 0), 32'd1);
            if (q1.size() > 0) begin
                e = q1.pop_front();
                check_output("sum_8x4", 32'(if8x4.sum), 32'(e.sum));
                check_output("cout_8x4", 32'(if8x4.cout), 32'(e.cout));
                check_output("ovf_8x4", 32'(if8x4.overflow), 32'(e.ovf));
            end
        end
    end

    always @(negedge clk) begin : mon_4x2
        exp_t e;
        if (if4x2.done === 1'b1) begin
            check_output("sb_pending_4x2", 32'(q2.size() > 0), 32'd1);
            if (q2.size() > 0) begin
                e = q2.pop_front();
                check_output("sum_4x2", 32'(if4x2.sum), 32'(e.sum));
                check_output("cout_4x2", 32'(if4x2.cout), 32'(e.cout));
                check_output("ovf_4x2", 32'(if4x2.overflow), 32'(e.ovf));
            end
        end
    end

    initial begin
        for (int s = 0; s < 3; s++)
            set_inputs(s, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        for (int s = 0; s < 3; s++)
            check_output("reset_outputs", 32'(get_outs(s)), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed add/sub cases at 8x1
        apply_stimulus(0, 8'h5A, 8'h3C, 1'b0, 1'b0, mk(8'h96, 1'b0, 1'b1), 8, -1);
        idle_check(0);
        check_output("sum_holds", 32'(if8x1.sum), 32'h96);
        apply_stimulus(0, 8'hFF, 8'h01, 1'b0, 1'b0, mk(8'h00, 1'b1, 1'b0), 8, -1);
        apply_stimulus(0, 8'h00, 8'h00, 1'b1, 1'b0, mk(8'h01, 1'b0, 1'b0), 8, -1);
        apply_stimulus(0, 8'h10, 8'h20, 1'b0, 1'b1, mk(8'hF0, 1'b0, 1'b0), 8, -1);
        apply_stimulus(0, 8'h80, 8'h01, 1'b0, 1'b1, mk(8'h7F, 1'b1, 1'b1), 8, -1);
        idle_check(0);

        // Start during RUN must be ignored
        apply_stimulus(0, 8'h12, 8'h34, 1'b0, 1'b0, mk(8'h46, 1'b0, 1'b0), 8, 3);
        idle_check(0);

        // 8x4: two slices, then back-to-back accept from DONE
        apply_stimulus(1, 8'hFF, 8'hFF, 1'b1, 1'b0, mk(8'hFF, 1'b1, 1'b0), 2, -1);
        apply_stimulus(1, 8'h01, 8'h02, 1'b0, 1'b0, mk(8'h03, 1'b0, 1'b0), 2, -1);
        idle_check(1);

        // Asynchronous reset mid-RUN aborts without a done pulse
        set_inputs(0, 8'h77, 8'h11, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        set_inputs(0, 8'h77, 8'h11, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check_output("busy_before_abort", 32'(get_busy(0)), 32'd1);
        #2 rst = 1'b1;
        #1 check_output("abort_outputs", 32'(get_outs(0)), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            check_output("no_done_after_abort", 32'(get_done(0)), 32'd0);
        end
        apply_stimulus(0, 8'h21, 8'h43, 1'b0, 1'b0, mk(8'h64, 1'b0, 1'b0), 8, -1);
        idle_check(0);

        // Exhaustive 4x2 against the reference model
        for (int sb = 0; sb < 2; sb++)
            for (int ci = 0; ci < 2; ci++)
                for (int av = 0; av < 16; av++)
                    for (int bv = 0; bv < 16; bv++)
                        apply_stimulus(2, 8'(av), 8'(bv), ci[0], sb[0],
                                       model(4, 8'(av), 8'(bv), ci[0], sb[0]), 2, -1);
        idle_check(2);

        check_output("scoreboard_drained", 32'(q0.size() + q1.size() + q2.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
